// File: rtl/seq_divider.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per clock.
// Start/busy/done handshake; divide-by-zero short-circuits straight to the done pulse.
module seq_divider (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [7:0] dividend_i,
    input  logic [3:0] divisor_i,
    output logic [7:0] quotient_o,
    output logic [3:0] remainder_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       div_by_zero_o
);

    localparam int unsigned DW = 8;
    localparam int unsigned VW = 4;
    localparam int unsigned RW = VW + 1;
    localparam int unsigned CW = 3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [RW-1:0] r_q, r_d;
    logic [DW-1:0] q_q, q_d;
    logic [VW-1:0] d_q, d_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [VW-1:0] rem_q, rem_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dbz_q, dbz_d;

    // One restoring step: shift {R,Q} left, trial-subtract D, keep on non-negative.
    logic [RW:0]   r_sh_c;
    logic          ge_c;
    logic [RW-1:0] r_next_c;
    logic [DW-1:0] q_next_c;

    always_comb begin
        r_sh_c   = {r_q, q_q[DW-1]};
        ge_c     = (r_sh_c >= (RW+1)'(d_q));
        r_next_c = ge_c ? RW'(r_sh_c - (RW+1)'(d_q)) : RW'(r_sh_c);
        q_next_c = {q_q[DW-2:0], ge_c};
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            count_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            count_q <= count_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        count_d = count_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (divisor_i != '0) begin
                        r_d     = '0;
                        q_d     = dividend_i;
                        d_d     = divisor_i;
                        count_d = '0;
                        dbz_d   = 1'b0;
                        state_d = CALC;
                    end else begin
                        quot_d  = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                r_d     = r_next_c;
                q_d     = q_next_c;
                count_d = count_q + CW'(1);
                if (count_q == CW'(7)) begin
                    quot_d  = q_next_c;
                    rem_d   = r_next_c[VW-1:0];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Handshake flags are registered copies of the state being entered.
        busy_d = (state_d == CALC);
        done_d = (state_d == DONE);
    end

    assign quotient_o    = quot_q;
    assign remainder_o   = rem_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: scoreboard of expected results, one task per scenario.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    typedef struct packed {
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    seq_divider dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .dividend_i   (dividend),
        .divisor_i    (divisor),
        .quotient_o   (quotient),
        .remainder_o  (remainder),
        .busy_o       (busy),
        .done_o       (done),
        .div_by_zero_o(div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [7:0] dd, input logic [3:0] dv);
        exp_t e;
        if (dv == 4'd0) begin
            e.q = 8'hFF; e.r = 4'd0; e.z = 1'b1;
        end else begin
            e.q = 8'(dd / dv); e.r = 4'(dd % dv); e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present operands for one edge and queue the expected result.
    task automatic issue(input logic [7:0] dd, input logic [3:0] dv);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        sb.push_back(model(dd, dv));
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(output int edges, output int busy_cnt, output bit timeout);
        edges = 0; busy_cnt = 0; timeout = 1'b0;
        while (!done) begin
            if (busy) busy_cnt++;
            if (edges >= 20) begin
                timeout = 1'b1;
                break;
            end
            tick;
            edges++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #20;
        checks++;
        if ({quotient, remainder, busy, done, div_by_zero} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0",
                     quotient, remainder, busy, done, div_by_zero);
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        int edges, bc; bit to; exp_t e;
        issue(8'd15, 4'd3);
        wait_done(edges, bc, to);
        checks++;
        if (to || edges !== 8) begin
            errors++;
            $display("FAIL basic_latency: done after %0d edges past start (timeout=%b), want 8", edges, to);
        end
        if (!to) begin
            e = sb.pop_front();
            checks++;
            if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
                errors++;
                $display("FAIL basic_result: got %0d r%0d z%b, want %0d r%0d z%b",
                         quotient, remainder, div_by_zero, e.q, e.r, e.z);
            end
        end
        tick;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b busy=%b one cycle later, want 0 0", done, busy);
        end
    endtask

    task automatic test_busy;
        int edges, bc; bit to; exp_t e;
        issue(8'd200, 4'd7);
        wait_done(edges, bc, to);
        checks++;
        if (to || bc !== 8 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_cycles: busy high %0d cycles, busy at done=%b, want 8 and 0", bc, busy);
        end
        if (!to) begin
            e = sb.pop_front();
            checks++;
            if ({quotient, remainder} !== {e.q, e.r}) begin
                errors++;
                $display("FAIL busy_result: got %0d r%0d, want %0d r%0d", quotient, remainder, e.q, e.r);
            end
        end
        tick;
    endtask

    task automatic test_boundaries;
        logic [7:0] dds [4] = '{8'd255, 8'd255, 8'd5, 8'd0};
        logic [3:0] dvs [4] = '{4'd1, 4'd15, 4'd9, 4'd4};
        int edges, bc; bit to; exp_t e;
        for (int i = 0; i < 4; i++) begin
            issue(dds[i], dvs[i]);
            wait_done(edges, bc, to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL boundary_%0d_timeout: no done for %0d/%0d", i, dds[i], dvs[i]);
                sb.delete();
            end else begin
                e = sb.pop_front();
                if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
                    errors++;
                    $display("FAIL boundary_%0d: %0d/%0d got %0d r%0d z%b, want %0d r%0d z%b",
                             i, dds[i], dvs[i], quotient, remainder, div_by_zero, e.q, e.r, e.z);
                end
            end
            tick;
        end
    endtask

    task automatic test_div_zero;
        int edges, bc; bit to; exp_t e;
        issue(8'd77, 4'd0);
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 ||
            {quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
            errors++;
            $display("FAIL div_zero: done=%b busy=%b q=%0h r=%0d z=%b, want 1 0 q=%0h r=%0d z=%b",
                     done, busy, quotient, remainder, div_by_zero, e.q, e.r, e.z);
        end
        tick;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL div_zero_after: done=%b busy=%b dbz=%b, want 0 0 1", done, busy, div_by_zero);
        end
        issue(8'd77, 4'd7);
        checks++;
        if (div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL div_zero_clear: dbz=%b after accepted start, want 0", div_by_zero);
        end
        wait_done(edges, bc, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL div_zero_recover_timeout: no done for 77/7");
            sb.delete();
        end else begin
            e = sb.pop_front();
            if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
                errors++;
                $display("FAIL div_zero_recover: got %0d r%0d z%b, want %0d r%0d z%b",
                         quotient, remainder, div_by_zero, e.q, e.r, e.z);
            end
        end
        tick;
    endtask

    task automatic test_ignore_start;
        int edges, bc, extra; bit to; exp_t e;
        issue(8'd100, 4'd3);
        tick; tick; tick;
        dividend = 8'd50; divisor = 4'd5; start = 1'b1;
        tick;
        start = 1'b0;
        wait_done(edges, bc, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL ignore_timeout: no done for 100/3");
            sb.delete();
            e = model(8'd100, 4'd3);
        end else begin
            e = sb.pop_front();
            if ({quotient, remainder} !== {e.q, e.r}) begin
                errors++;
                $display("FAIL ignore_result: got %0d r%0d, want %0d r%0d", quotient, remainder, e.q, e.r);
            end
        end
        extra = 0;
        for (int k = 0; k < 15; k++) begin
            tick;
            if (done) extra++;
        end
        checks++;
        if (extra !== 0 || busy !== 1'b0 || {quotient, remainder} !== {e.q, e.r}) begin
            errors++;
            $display("FAIL ignore_hold: extra dones=%0d busy=%b q=%0d r=%0d, want 0 0 %0d r%0d",
                     extra, busy, quotient, remainder, e.q, e.r);
        end
    endtask

    task automatic test_reset_mid;
        int edges, bc, stray; bit to; exp_t e;
        issue(8'd180, 4'd11);
        tick; tick; tick; tick;
        reset = 1'b1;
        #1;
        checks++;
        if ({quotient, remainder, busy, done, div_by_zero} !== 15'd0) begin
            errors++;
            $display("FAIL reset_mid_async: q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0",
                     quotient, remainder, busy, done, div_by_zero);
        end
        sb.delete();
        tick;
        reset = 1'b0;
        stray = 0;
        for (int k = 0; k < 12; k++) begin
            tick;
            if (done || busy) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL reset_mid_abandon: %0d cycles of done/busy after reset, want 0", stray);
        end
        issue(8'd180, 4'd11);
        wait_done(edges, bc, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL reset_mid_recover_timeout: no done for 180/11");
            sb.delete();
        end else begin
            e = sb.pop_front();
            if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
                errors++;
                $display("FAIL reset_mid_recover: got %0d r%0d z%b, want %0d r%0d z%b",
                         quotient, remainder, div_by_zero, e.q, e.r, e.z);
            end
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int ndone, pos[$]; exp_t e;
        dividend = 8'd200; divisor = 4'd13; start = 1'b1;
        sb.push_back(model(dividend, divisor));
        tick;
        ndone = 0;
        for (int k = 1; k <= 29; k++) begin
            tick;
            if (done) begin
                ndone++;
                pos.push_back(k);
                e = sb.pop_front();
                checks++;
                if ({quotient, remainder} !== {e.q, e.r}) begin
                    errors++;
                    $display("FAIL b2b_result_%0d: got %0d r%0d, want %0d r%0d",
                             ndone, quotient, remainder, e.q, e.r);
                end
                dividend = dividend - 8'd37;
                sb.push_back(model(dividend, divisor));
            end
        end
        start = 1'b0;
        sb.delete();
        checks++;
        if (ndone !== 3 || pos[0] !== 8 || pos[1] !== 18 || pos[2] !== 28) begin
            errors++;
            $display("FAIL b2b_spacing: %0d dones at edges %p, want 3 at 8 18 28", ndone, pos);
        end
        for (int k = 0; k < 12; k++) tick;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_busy;
        test_boundaries;
        test_div_zero;
        test_ignore_start;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
